// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART RX frame controller and its sampler:
// state encoding, parity type codes and default widths.
package uart_rx_frame_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESC_W_DEF    = 5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_frame_ctrl_edge_bit_cnt.sv
// Edge counter within one bit period plus data bit index, with enable,
// synchronous clear and a wrap flag at the last edge of each bit.
module uart_rx_frame_ctrl_edge_bit_cnt
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESC_W    = PRESC_W_DEF,
  localparam int BIT_W     = $clog2(DATA_WIDTH)
) (
  input  logic               Cnt_CLK,
  input  logic               Cnt_RST,
  input  logic               Cnt_clr,
  input  logic               Cnt_en,
  input  logic               Cnt_bit_en,
  input  logic [PRESC_W-1:0] Cnt_prescale,
  output logic [PRESC_W-1:0] Cnt_edge_cnt,
  output logic [BIT_W-1:0]   Cnt_bit_cnt,
  output logic               Cnt_wrap
);

  assign Cnt_wrap = Cnt_en && (Cnt_edge_cnt == Cnt_prescale - PRESC_W'(1));

  always_ff @(posedge Cnt_CLK) begin
    if (!Cnt_RST) begin
      Cnt_edge_cnt <= '0;
      Cnt_bit_cnt  <= '0;
    end else if (Cnt_clr) begin
      Cnt_edge_cnt <= '0;
      Cnt_bit_cnt  <= '0;
    end else if (Cnt_en) begin
      Cnt_edge_cnt <= Cnt_wrap ? '0 : Cnt_edge_cnt + PRESC_W'(1);
      if (Cnt_wrap && Cnt_bit_en) begin
        Cnt_bit_cnt <= (Cnt_bit_cnt == BIT_W'(DATA_WIDTH - 1)) ? '0
                                                                : Cnt_bit_cnt + BIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start detect, sampler control, LSB-first
// deserialization, parity/stop checks and one-cycle result pulses.
//
//  state  | meaning
//  IDLE   | line idle, waiting for a low level on RX_IN
//  START  | inside start bit; a high vote rejects it as a glitch
//  DATA   | shifting in DATA_WIDTH voted bits, LSB first
//  PARITY | capturing the parity vote (only when latched PAR_EN)
//  STOP   | first stop vote ends the frame and fires the result pulses
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESC_W    = PRESC_W_DEF,
  localparam int BIT_W     = $clog2(DATA_WIDTH)
) (
  input  logic                  RxCtrl_CLK,
  input  logic                  RxCtrl_RST,
  input  logic                  RxCtrl_RX_IN,
  input  logic                  RxCtrl_PAR_EN,
  input  logic                  RxCtrl_PAR_TYP,
  input  logic [PRESC_W-1:0]    RxCtrl_prescale,
  input  logic                  RxCtrl_sample,
  input  logic                  RxCtrl_sample_valid,
  output logic [PRESC_W-1:0]    RxCtrl_edge_cnt,
  output logic                  RxCtrl_data_samp_en,
  output logic [DATA_WIDTH-1:0] RxCtrl_P_DATA,
  output logic                  RxCtrl_data_valid,
  output logic                  RxCtrl_par_err,
  output logic                  RxCtrl_stp_err
);

  rx_state_e             state, next_state;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_q, par_typ_q, par_bad;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  wrap, cnt_clr, cnt_en, par_fail;

  uart_rx_frame_ctrl_edge_bit_cnt #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESC_W    (PRESC_W)
  ) u_cnt (
    .Cnt_CLK      (RxCtrl_CLK),
    .Cnt_RST      (RxCtrl_RST),
    .Cnt_clr      (cnt_clr),
    .Cnt_en       (cnt_en),
    .Cnt_bit_en   (state == ST_DATA),
    .Cnt_prescale (RxCtrl_prescale),
    .Cnt_edge_cnt (RxCtrl_edge_cnt),
    .Cnt_bit_cnt  (bit_cnt),
    .Cnt_wrap     (wrap)
  );

  always_ff @(posedge RxCtrl_CLK) begin
    if (!RxCtrl_RST) state <= ST_IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (!RxCtrl_RX_IN) next_state = ST_START;
      ST_START: begin
        if (RxCtrl_sample_valid && RxCtrl_sample) next_state = ST_IDLE;
        else if (wrap)                            next_state = ST_DATA;
      end
      ST_DATA: begin
        if (wrap && bit_cnt == BIT_W'(DATA_WIDTH - 1))
          next_state = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (wrap) next_state = ST_STOP;
      ST_STOP:   if (RxCtrl_sample_valid) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Clearing on the way into IDLE keeps edge_cnt at 0 for the whole idle period.
  always_comb begin
    RxCtrl_data_samp_en = (state != ST_IDLE);
    cnt_en              = (state != ST_IDLE);
    cnt_clr             = (next_state == ST_IDLE);
  end

  assign par_fail = par_bad && par_en_q;

  always_ff @(posedge RxCtrl_CLK) begin
    if (!RxCtrl_RST) begin
      shreg             <= '0;
      par_en_q          <= 1'b0;
      par_typ_q         <= 1'b0;
      par_bad           <= 1'b0;
      RxCtrl_P_DATA     <= '0;
      RxCtrl_data_valid <= 1'b0;
      RxCtrl_par_err    <= 1'b0;
      RxCtrl_stp_err    <= 1'b0;
    end else begin
      RxCtrl_data_valid <= 1'b0;
      RxCtrl_par_err    <= 1'b0;
      RxCtrl_stp_err    <= 1'b0;
      if (state == ST_IDLE && !RxCtrl_RX_IN) begin
        par_en_q  <= RxCtrl_PAR_EN;
        par_typ_q <= RxCtrl_PAR_TYP;
        par_bad   <= 1'b0;
      end
      if (RxCtrl_sample_valid) begin
        case (state)
          ST_DATA:   shreg <= {RxCtrl_sample, shreg[DATA_WIDTH-1:1]};
          ST_PARITY: par_bad <= RxCtrl_sample ^ (^shreg) ^ (par_typ_q == PAR_ODD);
          ST_STOP: begin
            RxCtrl_stp_err <= ~RxCtrl_sample;
            RxCtrl_par_err <= par_fail;
            if (RxCtrl_sample && !par_fail) begin
              RxCtrl_data_valid <= 1'b1;
              RxCtrl_P_DATA     <= shreg;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a frame-level timing model and a
// simple sampler model (vote = line value at the third-sample cycle).
module tb_uart_rx_frame_ctrl;

  localparam int DW   = 8;
  localparam int PW   = 5;
  localparam int NCYC = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_in = 1'b1;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic [PW-1:0] prescale = 5'd8;
  logic          sample, sample_valid;
  logic [PW-1:0] edge_cnt;
  logic          samp_en;
  logic [DW-1:0] p_data;
  logic          data_valid, par_err, stp_err;

  uart_rx_frame_ctrl dut (
    .RxCtrl_CLK          (clk),
    .RxCtrl_RST          (rst),
    .RxCtrl_RX_IN        (rx_in),
    .RxCtrl_PAR_EN       (par_en),
    .RxCtrl_PAR_TYP      (par_typ),
    .RxCtrl_prescale     (prescale),
    .RxCtrl_sample       (sample),
    .RxCtrl_sample_valid (sample_valid),
    .RxCtrl_edge_cnt     (edge_cnt),
    .RxCtrl_data_samp_en (samp_en),
    .RxCtrl_P_DATA       (p_data),
    .RxCtrl_data_valid   (data_valid),
    .RxCtrl_par_err      (par_err),
    .RxCtrl_stp_err      (stp_err)
  );

  always #5 clk = ~clk;

  assign sample_valid = samp_en && (int'(edge_cnt) == int'(prescale) / 2 + 2);
  assign sample       = rx_in;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected per-cycle behaviour, filled in when each frame is launched
  bit       exp_busy [NCYC];
  int       exp_edge [NCYC];
  bit       exp_dv   [NCYC];
  bit       exp_pe   [NCYC];
  bit       exp_se   [NCYC];
  bit       rst_clr  [NCYC];
  bit [7:0] dv_val   [NCYC];

  int n_cmp = 0;
  int n_bad = 0;
  int dv_count = 0, pe_count = 0, se_count = 0, last_dv_cyc = -1;
  logic [7:0] dv_q[$];
  logic [7:0] exp_pd = 8'h00;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      if (rst_clr[cyc]) exp_pd = 8'h00;
      if (exp_dv[cyc])  exp_pd = dv_val[cyc];
      chk("data_valid",   int'(data_valid), int'(exp_dv[cyc]));
      chk("par_err",      int'(par_err),    int'(exp_pe[cyc]));
      chk("stp_err",      int'(stp_err),    int'(exp_se[cyc]));
      chk("data_samp_en", int'(samp_en),    int'(exp_busy[cyc]));
      chk("edge_cnt",     int'(edge_cnt),   exp_edge[cyc]);
      chk("P_DATA",       int'(p_data),     int'(exp_pd));
      if (data_valid) begin
        dv_count++;
        last_dv_cyc = cyc;
        dv_q.push_back(p_data);
      end
      if (par_err) pe_count++;
      if (stp_err) se_count++;
    end
  end

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame starting this cycle; abort pulls reset low in data bit 4.
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt,
                            input bit pbit, input bit sbit, input bit abort);
    int t0, p, nb, ts, r, last;
    bit perr, serr;
    logic [10:0] bits;
    t0 = cyc;
    p  = int'(prescale);
    nb = pe ? 11 : 10;
    ts = t0 + 1 + (DW + 1 + (pe ? 1 : 0)) * p + p / 2 + 2;
    r  = t0 + 5 * p + 2;
    perr = pe && (pbit != ((^d) ^ pt));
    serr = !sbit;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1 + i] = d[i];
    if (pe) bits[9] = pbit;
    bits[nb - 1] = sbit;
    last = abort ? r : ts;
    for (int c = t0 + 1; c <= last && c < NCYC; c++) begin
      exp_busy[c] = 1'b1;
      exp_edge[c] = (c - t0 - 1) % p;
    end
    if (abort) begin
      if (r + 1 < NCYC) rst_clr[r + 1] = 1'b1;
    end else if (ts + 1 < NCYC) begin
      exp_pe[ts + 1] = perr;
      exp_se[ts + 1] = serr;
      exp_dv[ts + 1] = !perr && !serr;
      dv_val[ts + 1] = d;
    end
    par_en  = pe;
    par_typ = pt;
    for (int j = 0; j < nb; j++) begin
      for (int k = 0; k < p; k++) begin
        if (j == 3 && k == 0) begin
          par_en  = !pe;
          par_typ = !pt;
        end
        rx_in = bits[j];
        rst   = !(abort && cyc == r);
        @(posedge clk);
        #1;
        if (abort && cyc == r + 1) begin
          rst   = 1'b1;
          rx_in = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic glitch();
    int t0, p, ts;
    t0 = cyc;
    p  = int'(prescale);
    ts = t0 + 1 + p / 2 + 2;
    for (int c = t0 + 1; c <= ts; c++) begin
      exp_busy[c] = 1'b1;
      exp_edge[c] = (c - t0 - 1) % p;
    end
    rx_in = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    idle(ts - cyc + 4);
  endtask

  initial begin
    int t, dvc, pec, sec;
    for (int c = 1; c <= 4; c++) rst_clr[c] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset_P_DATA",   int'(p_data),   0);
    chk("reset_samp_en",  int'(samp_en),  0);
    chk("reset_edge_cnt", int'(edge_cnt), 0);
    idle(5);

    // prescale 8, no parity, 0xA5
    prescale = 5'd8;
    t = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("a5_latency", last_dv_cyc - t, 80);
    chk("a5_P_DATA",  int'(p_data), 'hA5);
    chk("a5_dv_count", dv_count, 1);

    // prescale 16, even parity, good then bad parity bit, then good odd parity
    prescale = 5'd16;
    idle(3);
    t = cyc;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("3c_latency", last_dv_cyc - t, 172);
    chk("3c_P_DATA",  int'(p_data), 'h3C);
    dvc = dv_count;
    pec = pe_count;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(10);
    chk("3c_bad_par_err", pe_count - pec, 1);
    chk("3c_bad_no_dv",   dv_count - dvc, 0);
    chk("3c_bad_P_DATA",  int'(p_data), 'h3C);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("07_odd_P_DATA", int'(p_data), 'h07);

    // start glitch
    prescale = 5'd8;
    idle(3);
    dvc = dv_count;
    glitch();
    chk("glitch_samp_en", int'(samp_en), 0);
    chk("glitch_no_dv",   dv_count - dvc, 0);

    // stop bit low followed at once by a new frame
    sec = se_count;
    dvc = dv_count;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("stop_err_count", se_count - sec, 1);
    chk("stop_next_dv",   dv_count - dvc, 1);
    chk("stop_next_data", int'(p_data), 'h96);

    // back-to-back frames
    dvc = dv_count;
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("b2b_dv_count", dv_count - dvc, 2);
    if (dv_q.size() >= 2) begin
      chk("b2b_first",  int'(dv_q[dv_q.size() - 2]), 'h01);
      chk("b2b_second", int'(dv_q[dv_q.size() - 1]), 'hFE);
    end else begin
      chk("b2b_queue_size", dv_q.size(), 2);
    end

    // reset during data bit 4
    dvc = dv_count;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_P_DATA",  int'(p_data),  0);
    chk("rst_samp_en", int'(samp_en), 0);
    idle(30);
    chk("rst_no_dv",   dv_count - dvc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
